// File: rtl/countdown_timer_ctrl_if.sv
// Control/status bundle for countdown_timer_ctrl: board-side commands in,
// count and status pulses out toward display/alarm logic.
interface countdown_timer_ctrl_if #(
  parameter int unsigned W = 16
);
  logic         start;
  logic         pause;
  logic         clear;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tick;
  logic         done;
  logic         busy;
  logic         paused;

  modport master (
    output start, pause, clear, load_val,
    input  count, tick, done, busy, paused
  );

  modport slave (
    input  start, pause, clear, load_val,
    output count, tick, done, busy, paused
  );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Prescaled down-counter sequencer with start/pause/resume/clear and done pulse.
// Optional feature: define AUTO_RELOAD_EN to reload the count at terminal tick.
module countdown_timer_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  countdown_timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic [31:0] PRE_LAST = 32'(TICK_DIV - 1);

  state_t       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [31:0]  pre_q, pre_d;
  logic         tick_q, tick_d;
  logic         done_q, done_d;
`ifdef AUTO_RELOAD_EN
  logic [W-1:0] reload_q, reload_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      pre_q    <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pre_q    <= pre_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pre_d    = pre_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.clear) begin
      state_d = IDLE;
      count_d = '0;
      pre_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            if (bus.load_val != '0) begin
              state_d  = RUN;
              count_d  = bus.load_val;
              pre_d    = '0;
`ifdef AUTO_RELOAD_EN
              reload_d = bus.load_val;
`endif
            end else begin
              state_d = DONE;
              count_d = '0;
              done_d  = 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.pause) state_d = PAUSE;
          if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
            // Terminal tick overrides a same-edge pause; <= guards against wrapping below 0.
            if (count_q <= W'(1)) begin
              done_d  = 1'b1;
`ifdef AUTO_RELOAD_EN
              count_d = reload_q;
`else
              count_d = '0;
              state_d = DONE;
`endif
            end else begin
              count_d = count_q - W'(1);
            end
          end else begin
            pre_d = pre_q + 32'd1;
          end
        end
        PAUSE: begin
          if (bus.start) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.count  = count_q;
  assign bus.tick   = tick_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q == RUN) || (state_q == PAUSE);
  assign bus.paused = (state_q == PAUSE);

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl (TICK_DIV=4, W=8): a cycle-level
// reference model pushes expected outputs, a negedge monitor pops and compares.
module tb_countdown_timer_ctrl;

  localparam int unsigned TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  countdown_timer_ctrl_if #(.W(8)) bus ();

  countdown_timer_ctrl #(.TICK_DIV(TD), .W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] count;
    logic       tick;
    logic       done;
    logic       busy;
    logic       paused;
  } obs_t;

  typedef enum {M_IDLE, M_RUN, M_HOLD, M_FIN} mode_t;

  obs_t        exp_q[$];
  mode_t       mode;
  int unsigned rem, reload, ran;

  // Reference: count = load minus completed periods of TD run clocks.
  always @(posedge clk or posedge rst) begin : model
    bit t, d;
    if (rst) begin
      mode   = M_IDLE;
      rem    = 0;
      ran    = 0;
      reload = 0;
      exp_q.delete();
    end else begin
      t = 1'b0;
      d = 1'b0;
      if (bus.clear) begin
        mode = M_IDLE;
        rem  = 0;
        ran  = 0;
      end else begin
        case (mode)
          M_IDLE, M_FIN: begin
            if (bus.start) begin
              if (bus.load_val == 8'd0) begin
                mode = M_FIN;
                rem  = 0;
                d    = 1'b1;
              end else begin
                mode   = M_RUN;
                rem    = bus.load_val;
                reload = bus.load_val;
                ran    = 0;
              end
            end
          end
          M_RUN: begin
            ran++;
            if (ran % TD == 0) begin
              t = 1'b1;
              rem--;
              if (rem == 0) begin
                d = 1'b1;
`ifdef AUTO_RELOAD_EN
                rem = reload;
`else
                mode = M_FIN;
`endif
              end
            end
            if (bus.pause && mode == M_RUN) mode = M_HOLD;
          end
          M_HOLD: begin
            if (bus.start) mode = M_RUN;
          end
          default: mode = M_IDLE;
        endcase
      end
      exp_q.push_back(obs_t'{8'(rem), t, d, (mode == M_RUN || mode == M_HOLD), (mode == M_HOLD)});
    end
  end

  always @(negedge clk) begin : monitor
    obs_t act, e;
    if (!rst) begin
      act = obs_t'{bus.count, bus.tick, bus.done, bus.busy, bus.paused};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty t=%0t act=%h required=<entry>", $time, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL sb t=%0t act{cnt,tk,dn,bsy,ps}=%h/%b%b%b%b required=%h/%b%b%b%b",
                   $time, act.count, act.tick, act.done, act.busy, act.paused,
                   e.count, e.tick, e.done, e.busy, e.paused);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0t act=%0d required=%0d", name, $time, act, req);
    end
  endtask

  task automatic cyc(input logic s, input logic p, input logic c, input logic [7:0] l);
    @(posedge clk);
    #2;
    bus.start    = s;
    bus.pause    = p;
    bus.clear    = c;
    bus.load_val = l;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_count"}, int'(bus.count), 0);
    chk({name, "_flags"}, int'({bus.tick, bus.done, bus.busy, bus.paused}), 0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.clear    = 1'b0;
    bus.load_val = 8'd0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    #1 rst = 1'b0;

`ifndef AUTO_RELOAD_EN
    // Load 3: ticks at +4/+8/+12, done with count 0 at +12.
    cyc(1'b1, 1'b0, 1'b0, 8'd3);
    idle(1);
    chk("t1_busy", int'(bus.busy), 1);
    chk("t1_count0", int'(bus.count), 3);
    idle(3);
    chk("t1_notick3", int'(bus.tick), 0);
    idle(1);
    chk("t1_tick4", int'(bus.tick), 1);
    chk("t1_count4", int'(bus.count), 2);
    idle(8);
    chk("t1_done12", int'(bus.done), 1);
    chk("t1_count12", int'(bus.count), 0);
    chk("t1_busy12", int'(bus.busy), 0);
    idle(1);
    chk("t1_done13", int'(bus.done), 0);

    // Pause sampled at +6, held 10 cycles, then resume.
    cyc(1'b1, 1'b0, 1'b0, 8'd3);
    idle(5);
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    idle(1);
    chk("t2_paused", int'(bus.paused), 1);
    chk("t2_count_hold", int'(bus.count), 2);
    idle(8);
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    idle(1);
    chk("t2_resumed", int'(bus.paused), 0);
    idle(1);
    chk("t2_notick", int'(bus.tick), 0);
    idle(1);
    chk("t2_tick", int'(bus.tick), 1);
    chk("t2_count1", int'(bus.count), 1);
    idle(4);
    chk("t2_done", int'(bus.done), 1);
`else
    // Auto-reload: load 2 counts 2,1,2,1 with done every 8 clocks.
    cyc(1'b1, 1'b0, 1'b0, 8'd2);
    idle(5);
    chk("ar_count4", int'(bus.count), 1);
    idle(4);
    chk("ar_done8", int'(bus.done), 1);
    chk("ar_count8", int'(bus.count), 2);
    chk("ar_busy8", int'(bus.busy), 1);
    idle(8);
    chk("ar_done16", int'(bus.done), 1);
    cyc(1'b0, 1'b0, 1'b1, 8'd0);
`endif

    // Load 0: immediate done, no tick, never busy.
    cyc(1'b1, 1'b0, 1'b0, 8'd0);
    idle(1);
    chk("t3_done", int'(bus.done), 1);
    chk("t3_tick", int'(bus.tick), 0);
    chk("t3_busy", int'(bus.busy), 0);
    idle(1);
    chk("t3_done_once", int'(bus.done), 0);

    // Clear at +9 aborts with no done.
    cyc(1'b1, 1'b0, 1'b0, 8'd5);
    idle(8);
    cyc(1'b0, 1'b0, 1'b1, 8'd0);
    idle(1);
    chk("t4_busy", int'(bus.busy), 0);
    chk("t4_count", int'(bus.count), 0);
    idle(20);

    // Asynchronous reset mid-run clears outputs without a clock edge.
    cyc(1'b1, 1'b0, 1'b0, 8'd5);
    idle(7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("t5_async");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Randomized command mix.
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(99);
      cyc(r < 10, (r >= 10 && r < 15), (r >= 98), 8'($urandom_range(5)));
    end
    idle(3);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
